// File: rtl/sa_host_driver.sv
// rtl/sa_host_driver.sv - host master: loads A/B/instruction memories, kicks the array, streams results out.
// Optional ap_done watchdog enabled by defining SA_DRV_TIMEOUT_EN.
module sa_host_driver #(
  parameter int A_WORDS  = 64,
  parameter int B_WORDS  = 64,
  parameter int I_WORDS  = 4,
  parameter int O_WORDS  = 64,
  parameter int READ_LAT = 1
`ifdef SA_DRV_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 4096
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  output logic [5:0]  addrA,
  output logic        enA,
  output logic [15:0] dataA,
  output logic [5:0]  addrB,
  output logic        enB,
  output logic [15:0] dataB,
  output logic [1:0]  addrI,
  output logic        enI,
  output logic [4:0]  dataI,
  output logic        ap_start,
  input  logic        ap_done,
  output logic [7:0]  addrO,
  input  logic [15:0] dataO,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_data,
  output logic        m_last
);

  localparam int LW = $clog2(READ_LAT + 2);
  localparam logic [6:0]    A_LAST   = 7'(A_WORDS - 1);
  localparam logic [6:0]    B_LAST   = 7'(B_WORDS - 1);
  localparam logic [6:0]    I_LAST   = 7'(I_WORDS - 1);
  localparam logic [7:0]    O_LAST   = 8'(O_WORDS - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'((READ_LAT > 0) ? READ_LAT - 1 : 0);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_LOAD_I, S_KICK, S_WAIT, S_RD_ADDR, S_RD_WAIT, S_RD_OUT
  } state_t;

  state_t        state_q;
  logic [6:0]    cnt_q;
  logic [LW-1:0] lat_q;
  logic          busy_q, done_q, s_ready_q, ap_start_q;
  logic          ena_q, enb_q, eni_q;
  logic [5:0]    addra_q, addrb_q;
  logic [1:0]    addri_q;
  logic [15:0]   dataa_q, datab_q;
  logic [4:0]    datai_q;
  logic [7:0]    addro_q;
  logic          m_valid_q, m_last_q;
  logic [15:0]   m_data_q;
`ifdef SA_DRV_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic          err_q;
  logic [TW-1:0] tcnt_q;
`endif

  logic hs;
  assign hs = s_valid & s_ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      lat_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      s_ready_q  <= 1'b0;
      ap_start_q <= 1'b0;
      ena_q      <= 1'b0;
      enb_q      <= 1'b0;
      eni_q      <= 1'b0;
      addra_q    <= '0;
      addrb_q    <= '0;
      addri_q    <= '0;
      dataa_q    <= '0;
      datab_q    <= '0;
      datai_q    <= '0;
      addro_q    <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_data_q   <= '0;
`ifdef SA_DRV_TIMEOUT_EN
      err_q      <= 1'b0;
      tcnt_q     <= '0;
`endif
    end else begin
      ena_q      <= 1'b0;
      enb_q      <= 1'b0;
      eni_q      <= 1'b0;
      ap_start_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // busy spans the done cycle, so a go coinciding with done is dropped
          if (done_q) begin
            busy_q <= 1'b0;
          end else if (go) begin
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            addro_q   <= '0;
            s_ready_q <= 1'b1;
            state_q   <= S_LOAD_A;
`ifdef SA_DRV_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
          end
        end
        S_LOAD_A: if (hs) begin
          ena_q   <= 1'b1;
          addra_q <= cnt_q[5:0];
          dataa_q <= s_data;
          if (cnt_q == A_LAST) begin
            cnt_q   <= '0;
            state_q <= S_LOAD_B;
          end else begin
            cnt_q <= cnt_q + 7'd1;
          end
        end
        S_LOAD_B: if (hs) begin
          enb_q   <= 1'b1;
          addrb_q <= cnt_q[5:0];
          datab_q <= s_data;
          if (cnt_q == B_LAST) begin
            cnt_q   <= '0;
            state_q <= S_LOAD_I;
          end else begin
            cnt_q <= cnt_q + 7'd1;
          end
        end
        S_LOAD_I: if (hs) begin
          eni_q   <= 1'b1;
          addri_q <= cnt_q[1:0];
          datai_q <= s_data[4:0];
          if (cnt_q == I_LAST) begin
            cnt_q      <= '0;
            s_ready_q  <= 1'b0;
            ap_start_q <= 1'b1;
            state_q    <= S_KICK;
          end else begin
            cnt_q <= cnt_q + 7'd1;
          end
        end
        S_KICK: begin
          state_q <= S_WAIT;
`ifdef SA_DRV_TIMEOUT_EN
          tcnt_q  <= '0;
`endif
        end
        S_WAIT: begin
          if (ap_done) begin
            addro_q <= '0;
            state_q <= S_RD_ADDR;
          end
`ifdef SA_DRV_TIMEOUT_EN
          else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
`endif
        end
        S_RD_ADDR: begin
          if (READ_LAT == 0) begin
            m_data_q  <= dataO;
            m_last_q  <= (addro_q == O_LAST);
            m_valid_q <= 1'b1;
            state_q   <= S_RD_OUT;
          end else begin
            lat_q   <= '0;
            state_q <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (lat_q == LAT_LAST) begin
            m_data_q  <= dataO;
            m_last_q  <= (addro_q == O_LAST);
            m_valid_q <= 1'b1;
            state_q   <= S_RD_OUT;
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        S_RD_OUT: if (m_ready) begin
          m_valid_q <= 1'b0;
          m_last_q  <= 1'b0;
          if (addro_q == O_LAST) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            addro_q <= addro_q + 8'd1;
            state_q <= S_RD_ADDR;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign s_ready  = s_ready_q;
  assign addrA    = addra_q;
  assign enA      = ena_q;
  assign dataA    = dataa_q;
  assign addrB    = addrb_q;
  assign enB      = enb_q;
  assign dataB    = datab_q;
  assign addrI    = addri_q;
  assign enI      = eni_q;
  assign dataI    = datai_q;
  assign ap_start = ap_start_q;
  assign addrO    = addro_q;
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign m_last   = m_last_q;
`ifdef SA_DRV_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
